// File: rtl/online_sd_to_tc.sv
// online_sd_to_tc: digit-serial MSD-first signed-digit to two's-complement converter
// using Q/QM on-the-fly conversion, one digit per clock. Rev 1.0
`default_nettype none

module online_sd_to_tc #(
   parameter int STAGE = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*(STAGE+12)-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [STAGE+12:0]     out_data,
   output logic                  busy
);

   localparam int NDIG = STAGE + 12;
   localparam int CW   = $clog2(NDIG);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [CW-1:0]     cnt;
   logic [2*NDIG-1:0] sr;
   logic [NDIG:0]     q;
   logic [NDIG:0]     qm;
   logic [NDIG:0]     q_nx;
   logic [NDIG:0]     qm_nx;
   logic [1:0]        digit;
   logic              accept;
   logic              last;

   assign digit  = sr[2*NDIG-1 -: 2];
   assign accept = in_valid && in_ready;
   assign last   = (state == CONV) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = CONV;
         CONV:    if (cnt == '0) state_nx = DONE;
         DONE:    if (out_ready) state_nx = in_valid ? CONV : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == CONV);
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   end

   // QM always tracks Q-1, so a -1 digit selects from QM instead of borrowing.
   // Encodings 00 and 11 both fall into the zero-digit default.
   always_comb begin
      q_nx  = {q[NDIG-1:0], 1'b0};
      qm_nx = {qm[NDIG-1:0], 1'b1};
      case (digit)
         2'b10: begin
            q_nx  = {q[NDIG-1:0], 1'b1};
            qm_nx = {q[NDIG-1:0], 1'b0};
         end
         2'b01: begin
            q_nx  = {qm[NDIG-1:0], 1'b1};
            qm_nx = {qm[NDIG-1:0], 1'b0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt       <= '0;
         sr        <= '0;
         q         <= '0;
         qm        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            sr  <= in_data;
            q   <= '0;
            qm  <= '1;
            cnt <= CW'(NDIG - 1);
         end else if (state == CONV) begin
            sr  <= {sr[2*NDIG-3:0], 2'b00};
            q   <= q_nx;
            qm  <= qm_nx;
            cnt <= cnt - 1'b1;
         end
         if (last) begin
            out_data  <= q_nx;
            out_valid <= 1'b1;
         end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/online_sd_to_tc.md
Name: online_sd_to_tc

Overview:
- Digit-serial, MSD-first on-the-fly converter. Takes one signed-digit (redundant, 2 bits/digit) word from the online FIR output register and returns it as a conventional two's-complement integer.
- Sits between the online FIR data_out and the conventional-number consumers (capture logic, error checker).
- Uses valid/ready handshakes on both sides. Processes one digit per clock using Q/QM on-the-fly conversion registers, so no carry-propagate adder is needed.

Parameters:
- Stage, 8: FIR input stage count; must match the upstream filter.
- NDIG, Stage+12: digit count of the input word. Derived localparam, not overridable.

Ports:
- clk  in  1: clock.
- nrst  in  1: reset, synchronous, active-low.
- in_valid  in  1: in_data valid.
- in_ready  out  1: converter can accept a word.
- in_data  in  2*NDIG: signed-digit word. Digit i occupies bits [2i+1:2i]: bit 2i+1 = positive bit p, bit 2i = negative bit n, digit value = p-n.
- out_valid  out  1: out_data valid.
- out_ready  in  1: consumer accepts out_data.
- out_data  out  NDIG+1: two's-complement result.
- busy  out  1: high in CONV state.

Behaviour:
- Value definition: value = sum over i=0..NDIG-1 of d_i*2^i.
  - Range is ±(2^NDIG-1), so it always fits NDIG+1 bits.
  - Encoding 2'b11 is a legal zero. Treat it identically to 2'b00.
- States: IDLE, CONV, DONE.
- Reset (nrst=0 at a clk edge), from any state including mid-CONV:
  - state=IDLE, out_valid=0, out_data=0, busy=0.
  - Counter, shift register, Q and QM all cleared to 0.
  - Any partially converted word is discarded.
- in_ready (combinational) = (state==IDLE) || (state==DONE && out_ready).
- Accept edge k (in_valid && in_ready):
  - Latch in_data into the digit shift register.
  - Set Q=0, QM=all ones (-1) and digit counter=NDIG-1.
  - Go to CONV. busy=1 from edge k.
- CONV, one digit per edge, MSD (index NDIG-1) first. All updates are modulo 2^(NDIG+1).
  - d=+1: Q<=2Q+1, QM<=2Q.
  - d=0: Q<=2Q, QM<=2QM+1.
  - d=-1: Q<=2QM+1, QM<=2QM.
  - Shift the digit register by 2 bits. Decrement the counter.
  - At the edge that consumes digit 0 (edge k+NDIG):
    - out_data<=final Q, out_valid<=1, state<=DONE, busy<=0.
- Latency: out_valid is first seen high after edge k+NDIG, i.e. NDIG cycles after accept. Throughput is one word per NDIG+1 cycles.
- DONE:
  - out_data and out_valid are held stable while out_ready=0. Indefinite backpressure is allowed.
  - On out_ready=1:
    - If in_valid=0: out_valid<=0, go to IDLE. out_data keeps its last value.
    - If in_valid=1: the pop and the new accept happen in the same cycle. out_valid<=0, go directly to CONV loading the new word. No bubble, no lost word.
- in_valid may toggle freely while in_ready=0. in_data is ignored outside accept edges.
- Q and QM are internal. Only the final Q is exposed.

Test Plan (Stage=8, NDIG=20, out 21 bits):
- Reset, then in_data=40'h0000000000 accepted at edge k -> out_valid rises at edge k+20; out_data=21'h000000; busy high exactly 20 cycles.
- in_data=40'h8000000000 (d19=+1) -> out_data=21'h080000 (524288). in_data=40'h8000000001 (d19=+1, d0=-1) -> 21'h07FFFF.
- in_data=40'h5555555555 (all -1) -> 21'h100001 (-1048575). in_data=40'h0000000006 (d1=-1, d0=+1) -> 21'h1FFFFF (-1). in_data=40'hFFFFFFFFFF (all 2'b11) -> 21'h000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data and out_valid held, in_ready=0. Then raise out_ready with in_valid=1 -> same-cycle pop+accept; the next result appears 20 cycles later.
- Back-to-back stream of 8 random words with random out_ready stalls -> every output equals the reference sum; none dropped or duplicated; order preserved.
- Reset asserted at the 7th CONV cycle -> next edge: state IDLE, out_valid=0, out_data=0, in_ready=1. A new word 40'h8000000000 then converts cleanly to 21'h080000.
